bcrypt_expand_key_p: RTL and testbench

BCRYPT_EXPAND_KEY_P -- requirements
Module: bcrypt_expand_key_p

---
 rtl/bcrypt_expand_key_p.sv | 186 ++++++++++++++++++
 tb/tb_bcrypt_expand_key_p.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcrypt_expand_key_p.sv
`default_nettype none
// ============================================================================
// Module   : bcrypt_expand_key_p
// Function : Cyclic bcrypt key expansion. Key bytes are streamed out of the
//            storage as 32-bit big-endian words through a small output FIFO.
//            Define BCRYPT_SIGN_EXT_BUG_EN to add the sign_extension_bug port,
//            which selects the $2x sign-extending accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module bcrypt_expand_key_p #(
    parameter int KEY_LEN    = 72,
    parameter int EK_WORDS   = 18,
    parameter int OBUF_DEPTH = 2
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic [7:0]                     din,
    output logic [$clog2(KEY_LEN)-1:0]     rd_addr,
    input  logic                           word_empty,
    output logic                           word_set_empty,
    input  logic                           len_mode,
    input  logic [$clog2(KEY_LEN+1)-1:0]   key_len,
`ifdef BCRYPT_SIGN_EXT_BUG_EN
    input  logic                           sign_extension_bug,
`endif
    output logic [31:0]                    dout,
    input  logic                           rd_en,
    output logic                           empty
);

    localparam int c_ADDR_W = $clog2(KEY_LEN);
    localparam int c_KEY_W  = $clog2(KEY_LEN + 1);
    localparam int c_WCNT_W = $clog2(EK_WORDS + 1);
    localparam int c_PTR_W  = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(OBUF_DEPTH + 1);
    localparam int c_SLOTS  = 2 ** c_PTR_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INPUT   = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_mode;
    logic [c_KEY_W-1:0]    r_klen;
    logic [c_ADDR_W-1:0]   r_addr;
    logic [31:0]           r_acc;
    logic [1:0]            r_bcnt;
    logic [c_WCNT_W-1:0]   r_wcnt;
    logic [31:0]           r_mem [c_SLOTS];
    logic [c_PTR_W-1:0]    r_wp;
    logic [c_PTR_W-1:0]    r_rp;
    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_full;
    logic                  w_pop;
    logic                  w_take;
    logic                  w_push;
    logic                  w_last;
    logic                  w_zero_key;
    logic [7:0]            w_byte;
    logic [31:0]           w_acc_next;
    logic [c_ADDR_W-1:0]   w_addr_next;

    assign w_full     = (r_cnt == c_CNT_W'(OBUF_DEPTH));
    assign w_pop      = rd_en && (r_cnt != '0);
    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign w_take     = (r_state == S_INPUT) && (!w_full || w_pop);
    assign w_push     = w_take && (r_bcnt == 2'd3);
    assign w_last     = w_push && (r_wcnt == c_WCNT_W'(EK_WORDS - 1));
    assign w_zero_key = r_mode && (r_klen == '0);
    assign w_byte     = w_zero_key ? 8'h00 : din;

`ifdef BCRYPT_SIGN_EXT_BUG_EN
    assign w_acc_next = sign_extension_bug ? ((r_acc << 8) | {{24{w_byte[7]}}, w_byte})
                                           : {r_acc[23:0], w_byte};
`else
    assign w_acc_next = {r_acc[23:0], w_byte};
`endif

    always_comb begin
        w_addr_next = r_addr + c_ADDR_W'(1);
        if (w_zero_key) begin
            w_addr_next = '0;
        end else if (!r_mode && (din == 8'h00)) begin
            w_addr_next = '0;
        end else if (r_mode && ((c_KEY_W'(r_addr) + c_KEY_W'(1)) == r_klen)) begin
            w_addr_next = '0;
        end else if (r_addr == c_ADDR_W'(KEY_LEN - 1)) begin
            w_addr_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        word_set_empty = 1'b0;
        case (r_state)
            S_IDLE:    if (!word_empty) w_state_next = S_INPUT;
            S_INPUT:   if (w_last) w_state_next = S_DRAIN;
            S_DRAIN:   if (r_cnt == '0) w_state_next = S_RELEASE;
            S_RELEASE: begin
                word_set_empty = 1'b1;
                w_state_next   = S_IDLE;
            end
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_mode <= 1'b0;
            r_klen <= '0;
            r_addr <= '0;
            r_acc  <= '0;
            r_bcnt <= '0;
            r_wcnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!word_empty) begin
                        r_mode <= len_mode;
                        r_klen <= key_len;
                        r_addr <= '0;
                        r_acc  <= '0;
                        r_bcnt <= '0;
                        r_wcnt <= '0;
                    end
                end
                S_INPUT: begin
                    if (w_take) begin
                        r_acc  <= w_acc_next;
                        r_bcnt <= r_bcnt + 2'd1;
                        r_addr <= w_addr_next;
                        if (w_push) begin
                            r_wcnt <= r_wcnt + c_WCNT_W'(1);
                        end
                    end
                end
                S_RELEASE: r_addr <= '0;
                default:   ;
            endcase
        end
    end

    // Output FIFO: circular buffer with an explicit occupancy count.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < c_SLOTS; i++) begin
                r_mem[i] <= '0;
            end
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_acc_next;
                r_wp        <= (r_wp == c_PTR_W'(OBUF_DEPTH - 1)) ? '0 : r_wp + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= (r_rp == c_PTR_W'(OBUF_DEPTH - 1)) ? '0 : r_rp + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rd_addr = r_addr;
    assign empty   = (r_cnt == '0);
    assign dout    = (r_cnt == '0) ? 32'd0 : r_mem[r_rp];

endmodule
`default_nettype wire

// File: tb/tb_bcrypt_expand_key_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcrypt_expand_key_p
// Function : Directed scoreboard bench for bcrypt_expand_key_p (default build
//            and, with BCRYPT_SIGN_EXT_BUG_EN, the sign-extension variant).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcrypt_expand_key_p;

    logic        CLK = 1'b0;
    logic        reset;
    logic [7:0]  din;
    logic [6:0]  rd_addr;
    logic        word_empty;
    logic        word_set_empty;
    logic        len_mode;
    logic [6:0]  key_len;
`ifdef BCRYPT_SIGN_EXT_BUG_EN
    logic        sign_extension_bug;
`endif
    logic [31:0] dout;
    logic        rd_en;
    logic        empty;

    logic [7:0]  din4;
    logic [1:0]  rd_addr4;
    logic        word_empty4;
    logic        word_set_empty4;
    logic        len_mode4;
    logic [2:0]  key_len4;
    logic [31:0] dout4;
    logic        rd_en4;
    logic        empty4;

    logic [7:0]  mem  [72];
    logic [7:0]  mem4 [4];
    logic [31:0] q [$];
    logic [31:0] got  [256];
    logic [31:0] got4 [16];
    int          got_n = 0;
    int          got4_n = 0;
    int          pulses = 0;
    int          pulses4 = 0;
    int          watch_max = 127;
    logic        hit = 1'b0;
    int          n_vec = 0;
    int          n_mis = 0;

    assign din  = mem[rd_addr];
    assign din4 = mem4[rd_addr4];

    always #5 CLK = ~CLK;

    bcrypt_expand_key_p #(.KEY_LEN(72), .EK_WORDS(18), .OBUF_DEPTH(2)) u_dut (
        .CLK                (CLK),
        .reset              (reset),
        .din                (din),
        .rd_addr            (rd_addr),
        .word_empty         (word_empty),
        .word_set_empty     (word_set_empty),
        .len_mode           (len_mode),
        .key_len            (key_len),
`ifdef BCRYPT_SIGN_EXT_BUG_EN
        .sign_extension_bug (sign_extension_bug),
`endif
        .dout               (dout),
        .rd_en              (rd_en),
        .empty              (empty)
    );

    bcrypt_expand_key_p #(.KEY_LEN(4), .EK_WORDS(4), .OBUF_DEPTH(1)) u_dut4 (
        .CLK                (CLK),
        .reset              (reset),
        .din                (din4),
        .rd_addr            (rd_addr4),
        .word_empty         (word_empty4),
        .word_set_empty     (word_set_empty4),
        .len_mode           (len_mode4),
        .key_len            (key_len4),
`ifdef BCRYPT_SIGN_EXT_BUG_EN
        .sign_extension_bug (sign_extension_bug),
`endif
        .dout               (dout4),
        .rd_en              (rd_en4),
        .empty              (empty4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc();
        logic rel;
        logic rel4;
        logic [31:0] e;
        rel  = 1'b0;
        rel4 = 1'b0;
        @(negedge CLK);
        if (!reset && !empty && rd_en) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("sb_word", dout, e);
            end
            if (got_n < 256) got[got_n] = dout;
            got_n++;
        end
        if (!reset && !empty4 && rd_en4) begin
            if (got4_n < 16) got4[got4_n] = dout4;
            got4_n++;
        end
        if (word_set_empty) begin
            pulses++;
            rel = 1'b1;
        end
        if (word_set_empty4) begin
            pulses4++;
            rel4 = 1'b1;
        end
        if (int'(rd_addr) > watch_max) hit = 1'b1;
        @(posedge CLK);
        #1;
        if (rel)  word_empty  = 1'b1;
        if (rel4) word_empty4 = 1'b1;
    endtask

    // Reference stream: walk the key storage byte by byte and pack 18 words.
    task automatic push_expected(input logic mode, input int klen, input logic sx);
        int          a;
        logic [31:0] acc;
        logic [7:0]  b;
        a   = 0;
        acc = 32'd0;
        for (int w = 0; w < 18; w++) begin
            for (int k = 0; k < 4; k++) begin
                b = (mode && klen == 0) ? 8'h00 : mem[a];
                if (sx) acc = (acc << 8) | {{24{b[7]}}, b};
                else    acc = {acc[23:0], b};
                if (mode && klen == 0)       a = 0;
                else if (!mode && b == 8'h00) a = 0;
                else if (mode && a == klen - 1) a = 0;
                else if (a == 71)             a = 0;
                else                          a = a + 1;
            end
            q.push_back(acc);
        end
    endtask

    task automatic load_key(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < 72; i++) mem[i] = 8'h00;
        mem[0] = b0;
        mem[1] = b1;
        mem[2] = b2;
        mem[3] = b3;
    endtask

    task automatic run_key(input string tag, input int base);
        int pb;
        int t;
        pb = pulses;
        t  = 0;
        word_empty = 1'b0;
        while (pulses == pb && t < 500) begin
            cyc();
            t++;
        end
        repeat (4) cyc();
        chk({tag, "_release"}, 32'(pulses - pb), 32'd1);
        chk({tag, "_sb_empty"}, 32'(q.size()), 32'd0);
        chk({tag, "_count"}, 32'(got_n - base), 32'd18);
    endtask

    initial begin
        int base;
        int pb;
        int t;
        reset       = 1'b1;
        word_empty  = 1'b1;
        word_empty4 = 1'b1;
        len_mode    = 1'b0;
        key_len     = 7'd0;
        len_mode4   = 1'b0;
        key_len4    = 3'd0;
        rd_en       = 1'b0;
        rd_en4      = 1'b1;
`ifdef BCRYPT_SIGN_EXT_BUG_EN
        sign_extension_bug = 1'b0;
`endif
        load_key(8'h61, 8'h62, 8'h00, 8'h00);
        mem4[0] = 8'h77; mem4[1] = 8'h78; mem4[2] = 8'h79; mem4[3] = 8'h7A;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_set_empty", 32'(word_set_empty), 32'd0);
        chk("rst_empty4", 32'(empty4), 32'd1);

        // "ab\0", NUL-terminated wrap, free-running reader
        rd_en = 1'b1;
        base = got_n;
        push_expected(1'b0, 0, 1'b0);
        run_key("nul", base);
        chk("nul_w0", got[base],     32'h61620061);
        chk("nul_w1", got[base + 1], 32'h62006162);
        chk("nul_w2", got[base + 2], 32'h00616200);

        // explicit length 3 over "abcd": 'd' must never be addressed
        load_key(8'h61, 8'h62, 8'h63, 8'h64);
        len_mode  = 1'b1;
        key_len   = 7'd3;
        watch_max = 2;
        hit       = 1'b0;
        base = got_n;
        push_expected(1'b1, 3, 1'b0);
        run_key("len3", base);
        chk("len3_w0", got[base], 32'h61626361);
        chk("len3_no_d", 32'(hit), 32'd0);

        // explicit length 0: zero bytes, address pinned at 0
        key_len   = 7'd0;
        watch_max = 0;
        hit       = 1'b0;
        base = got_n;
        push_expected(1'b1, 0, 1'b0);
        run_key("len0", base);
        chk("len0_w0", got[base], 32'h00000000);
        chk("len0_addr", 32'(hit), 32'd0);
        watch_max = 127;

        // backpressure: two words buffered, then the reader stalls
        load_key(8'h61, 8'h62, 8'h00, 8'h00);
        len_mode = 1'b0;
        rd_en    = 1'b0;
        base = got_n;
        push_expected(1'b0, 0, 1'b0);
        word_empty = 1'b0;
        repeat (30) cyc();
        chk("bp_not_empty", 32'(empty), 32'd0);
        chk("bp_dout_head", dout, 32'h61620061);
        chk("bp_rd_addr", 32'(rd_addr), 32'd2);
        repeat (5) cyc();
        chk("bp_rd_addr_frozen", 32'(rd_addr), 32'd2);
        chk("bp_dout_hold", dout, 32'h61620061);
        rd_en = 1'b1;
        run_key("bp", base);

        // reset mid-key after the fifth word
        base = got_n;
        pb   = pulses;
        push_expected(1'b0, 0, 1'b0);
        word_empty = 1'b0;
        t = 0;
        while ((got_n - base) < 5 && t < 200) begin
            cyc();
            t++;
        end
        chk("mid_five_words", 32'(got_n - base >= 5), 32'd1);
        reset = 1'b1;
        rd_en = 1'b0;
        q.delete();
        cyc();
        reset = 1'b0;
        chk("mid_empty", 32'(empty), 32'd1);
        chk("mid_rd_addr", 32'(rd_addr), 32'd0);
        chk("mid_dout", dout, 32'd0);
        chk("mid_set_empty", 32'(word_set_empty), 32'd0);
        chk("mid_no_pulse", 32'(pulses - pb), 32'd0);
        base = got_n;
        push_expected(1'b0, 0, 1'b0);
        rd_en = 1'b1;
        run_key("reread", base);
        chk("reread_w0", got[base], 32'h61620061);

        // high-bit byte stream 80 01 00
        load_key(8'h80, 8'h01, 8'h00, 8'h00);
`ifdef BCRYPT_SIGN_EXT_BUG_EN
        sign_extension_bug = 1'b1;
        base = got_n;
        push_expected(1'b0, 0, 1'b1);
        run_key("sx1", base);
        chk("sx1_w0", got[base], 32'hFFFFFF80);
        sign_extension_bug = 1'b0;
`endif
        base = got_n;
        push_expected(1'b0, 0, 1'b0);
        run_key("sx0", base);
        chk("sx0_w0", got[base], 32'h80010080);

        // 4-byte storage "wxyz" without NUL: overflow guard wraps the address
        pb = pulses4;
        t  = 0;
        word_empty4 = 1'b0;
        while (pulses4 == pb && t < 200) begin
            cyc();
            t++;
        end
        repeat (3) cyc();
        chk("wrap_release", 32'(pulses4 - pb), 32'd1);
        chk("wrap_count", 32'(got4_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap_w%0d", i), got4[i], 32'h7778797A);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
